// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//
// MIPS execute pipeline stage. Holds one instruction between decode and
// memory, evaluates it through a 12-bit one-hot ALU and owns the HI/LO
// registers used by the multiply/divide instructions.
//
// Multiplies are single cycle and commit HI/LO when the instruction hands off
// to memory. Divides run an iterative restoring divider (one quotient bit per
// cycle) and commit HI/LO on the last divide step. The instruction then waits
// in a DONE state until memory accepts it.
//
// Ports
//   clock                   sole clock, rising edge
//   reset_n                 asynchronous active-low reset
//   flush                   kill the held instruction and any divide in flight
//   decode_valid            decode presents an instruction
//   execute_allowin         this stage can accept an instruction this cycle
//   decode_alu_operation    one-hot ALU op, bit 0..11 =
//                           add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui
//   decode_src1/src2        operands (shift amount is src1[4:0])
//   decode_md_op            0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,
//                           7 mfhi,8 mflo
//   decode_trap_overflow    add/sub overflow raises an exception
//   decode_dest             destination GPR (0 = none)
//   decode_pc               instruction PC
//   memory_allowin          memory stage accepts this cycle
//   execute_to_memory_valid held instruction is ready to hand off
//   execute_result          ALU result, or HI/LO for mfhi/mflo
//   execute_dest            destination, 0 when the instruction traps
//   execute_pc              registered PC
//   execute_exception       overflow exception for the held instruction
// ---------------------------------------------------------------------------
module execute_stage #(
   parameter int DIV_STEPS = 32
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        decode_valid,
   output logic        execute_allowin,
   input  logic [11:0] decode_alu_operation,
   input  logic [31:0] decode_src1,
   input  logic [31:0] decode_src2,
   input  logic [3:0]  decode_md_op,
   input  logic        decode_trap_overflow,
   input  logic [4:0]  decode_dest,
   input  logic [31:0] decode_pc,
   input  logic        memory_allowin,
   output logic        execute_to_memory_valid,
   output logic [31:0] execute_result,
   output logic [4:0]  execute_dest,
   output logic [31:0] execute_pc,
   output logic        execute_exception
);

   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_DIVIDE,
      DIV_DONE
   } div_state_t;

   // Pipeline registers
   logic        valid;
   logic [11:0] alu_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [3:0]  md_op;
   logic        trap;
   logic [4:0]  dest;
   logic [31:0] pc;

   // Architectural HI/LO
   logic [31:0] hi;
   logic [31:0] lo;

   // Divider state
   div_state_t  div_state;
   div_state_t  div_state_next;
   logic [4:0]  div_count;
   logic [31:0] div_quot;
   logic [31:0] div_divisor;
   logic [31:0] div_rem;

   // Handshake and control strobes
   logic        ready_go;
   logic        capture;
   logic        handoff;
   logic        decode_is_div;
   logic        div_last;
   logic        div_write;

   // ALU signals
   logic [31:0] add_res;
   logic [31:0] sub_res;
   logic        add_ovf;
   logic        sub_ovf;
   logic        slt_res;
   logic        sltu_res;
   logic [31:0] sra_res;
   logic [31:0] alu_result;
   logic        alu_overflow;
   logic        exception;

   // Divider datapath signals
   logic [32:0] rem_shift;
   logic        step_ge;
   logic [32:0] step_diff;
   logic [31:0] rem_next;
   logic [31:0] quot_next;
   logic        div_signed;
   logic        quot_neg;
   logic        rem_neg;
   logic [31:0] quot_final;
   logic [31:0] rem_final;

   logic [31:0] dividend_abs;
   logic [31:0] divisor_abs;

   logic signed [63:0] prod_signed;
   logic [63:0]        prod_unsigned;

   // A divide blocks hand-off until its final step has committed HI/LO.
   assign ready_go                = (div_state != DIV_DIVIDE);
   assign execute_allowin         = !valid || (ready_go && memory_allowin);
   assign execute_to_memory_valid = valid && ready_go;

   // Flush wins over a capture or hand-off happening on the same edge.
   assign capture       = decode_valid && execute_allowin && !flush;
   assign handoff       = execute_to_memory_valid && memory_allowin && !flush;
   assign decode_is_div = (decode_md_op == MD_DIV) || (decode_md_op == MD_DIVU);

   // ALU, evaluated from the registered operands
   always_comb begin
      add_res  = src1 + src2;
      sub_res  = src1 - src2;
      add_ovf  = (src1[31] == src2[31]) && (add_res[31] != src1[31]);
      sub_ovf  = (src1[31] != src2[31]) && (sub_res[31] != src1[31]);
      slt_res  = $signed(src1) < $signed(src2);
      sltu_res = src1 < src2;
      sra_res  = $signed(src2) >>> src1[4:0];

      alu_result = ({32{alu_op[0]}}  & add_res)
                 | ({32{alu_op[1]}}  & sub_res)
                 | ({32{alu_op[2]}}  & {31'd0, slt_res})
                 | ({32{alu_op[3]}}  & {31'd0, sltu_res})
                 | ({32{alu_op[4]}}  & (src1 & src2))
                 | ({32{alu_op[5]}}  & ~(src1 | src2))
                 | ({32{alu_op[6]}}  & (src1 | src2))
                 | ({32{alu_op[7]}}  & (src1 ^ src2))
                 | ({32{alu_op[8]}}  & (src2 << src1[4:0]))
                 | ({32{alu_op[9]}}  & (src2 >> src1[4:0]))
                 | ({32{alu_op[10]}} & sra_res)
                 | ({32{alu_op[11]}} & {src2[15:0], 16'd0});

      alu_overflow = (alu_op[0] && add_ovf) || (alu_op[1] && sub_ovf);
   end

   assign exception = valid && trap && alu_overflow;

   // mfhi/mflo read the live HI/LO so a just-committed mult/div is visible.
   always_comb begin
      execute_result = alu_result;
      if (md_op == MD_MFHI) begin
         execute_result = hi;
      end else if (md_op == MD_MFLO) begin
         execute_result = lo;
      end
   end

   assign execute_dest      = exception ? 5'd0 : dest;
   assign execute_pc        = pc;
   assign execute_exception = exception;

   // Operand magnitudes loaded into the divider when a divide is captured.
   always_comb begin
      dividend_abs = decode_src1;
      divisor_abs  = decode_src2;
      if (decode_md_op == MD_DIV) begin
         if (decode_src1[31]) begin
            dividend_abs = -decode_src1;
         end
         if (decode_src2[31]) begin
            divisor_abs = -decode_src2;
         end
      end
   end

   // One restoring step: the dividend shifts out of div_quot MSB-first while
   // quotient bits shift in at the bottom of the same register.
   always_comb begin
      rem_shift = {div_rem, div_quot[31]};
      step_ge   = rem_shift >= {1'b0, div_divisor};
      step_diff = rem_shift - {1'b0, div_divisor};
      rem_next  = step_ge ? step_diff[31:0] : rem_shift[31:0];
      quot_next = {div_quot[30:0], step_ge};
   end

   // Sign fix-up for the final write. The held src1/src2 are still the raw
   // divide operands because nothing new is captured while dividing.
   always_comb begin
      div_signed = (md_op == MD_DIV);
      quot_neg   = div_signed && (src1[31] ^ src2[31]);
      rem_neg    = div_signed && src1[31];
      quot_final = quot_neg ? -quot_next : quot_next;
      rem_final  = rem_neg ? -rem_next : rem_next;
      if (src2 == 32'd0) begin
         quot_final = 32'hFFFF_FFFF;
         rem_final  = src1;
      end
   end

   assign div_last  = (div_state == DIV_DIVIDE) && (div_count == LAST_STEP);
   assign div_write = div_last && !flush && !exception;

   assign prod_signed   = $signed(src1) * $signed(src2);
   assign prod_unsigned = {32'd0, src1} * {32'd0, src2};

   // Pipeline register capture; valid follows decode whenever we can accept.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid  <= 1'b0;
         alu_op <= '0;
         src1   <= '0;
         src2   <= '0;
         md_op  <= '0;
         trap   <= 1'b0;
         dest   <= '0;
         pc     <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (execute_allowin) begin
         valid <= decode_valid;
         if (decode_valid) begin
            alu_op <= decode_alu_operation;
            src1   <= decode_src1;
            src2   <= decode_src2;
            md_op  <= decode_md_op;
            trap   <= decode_trap_overflow;
            dest   <= decode_dest;
            pc     <= decode_pc;
         end
      end
   end

   // Divider state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_state <= DIV_IDLE;
      end else begin
         div_state <= div_state_next;
      end
   end

   // Divider next state: a new divide starts on its capture edge, the DONE
   // state is released by the hand-off, and flush always returns to IDLE.
   always_comb begin
      div_state_next = div_state;
      case (div_state)
         DIV_IDLE:   div_state_next = DIV_IDLE;
         DIV_DIVIDE: if (div_count == LAST_STEP) div_state_next = DIV_DONE;
         DIV_DONE:   if (handoff) div_state_next = DIV_IDLE;
         default:    div_state_next = DIV_IDLE;
      endcase
      if (capture && decode_is_div) begin
         div_state_next = DIV_DIVIDE;
      end
      if (flush) begin
         div_state_next = DIV_IDLE;
      end
   end

   // Divider datapath: load magnitudes on capture, step while dividing.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_count   <= '0;
         div_quot    <= '0;
         div_divisor <= '0;
         div_rem     <= '0;
      end else if (flush) begin
         div_count <= '0;
      end else if (capture && decode_is_div) begin
         div_count   <= '0;
         div_quot    <= dividend_abs;
         div_divisor <= divisor_abs;
         div_rem     <= '0;
      end else if (div_state == DIV_DIVIDE) begin
         div_count <= div_count + 5'd1;
         div_quot  <= quot_next;
         div_rem   <= rem_next;
      end
   end

   // HI/LO: divides commit on their last step, everything else on hand-off,
   // and a trapping instruction never touches them.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hi <= '0;
         lo <= '0;
      end else if (div_write) begin
         hi <= rem_final;
         lo <= quot_final;
      end else if (handoff && !exception) begin
         case (md_op)
            MD_MULT:  {hi, lo} <= prod_signed;
            MD_MULTU: {hi, lo} <= prod_unsigned;
            MD_MTHI:  hi <= src1;
            MD_MTLO:  lo <= src1;
            default:  ;
         endcase
      end
   end

endmodule
